mips_mem_mmio: RTL and testbench



---
 rtl/mips_mmio_pkg.sv | 36 +++
 rtl/mips_mem_mmio_uart_tx.sv | 91 +++++++++
 rtl/mips_mem_mmio.sv | 138 +++++++++++++
 tb/tb_mips_mem_mmio.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mmio_pkg
//  Purpose  : Shared constants and types for the MIPS memory / MMIO system:
//             MMIO page base, register offsets, STATUS bit positions and the
//             UART transmitter state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_mmio_pkg;

   // Upper half of a byte address that selects the MMIO page
   localparam logic [15:0] MMIO_BASE  = 16'hFFFF;

   // Register offsets inside the MMIO page (bits [1:0] are ignored)
   localparam logic [15:0] OFF_TXDATA = 16'h0000;
   localparam logic [15:0] OFF_STATUS = 16'h0004;
   localparam logic [15:0] OFF_LEDS   = 16'h0008;
   localparam logic [15:0] OFF_CYCLE  = 16'h000C;

   // STATUS register bit positions
   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   // UART transmitter states
   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_mem_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1 serial transmitter with a valid/ready byte input. A byte is
//             taken whenever the line is idle, or at the end of a stop bit so
//             that queued frames go out back-to-back.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
   import mips_mmio_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);

   localparam int            BW     = $clog2(CLK_DIV);
   localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);

   uart_state_t   state;
   uart_state_t   state_nxt;
   logic [BW-1:0] baud_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;
   logic          bit_done;
   logic          fire;

   assign bit_done = (baud_cnt == '0);
   assign fire     = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rstb) state <= UART_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: each bit lasts until the baud counter reaches zero
   always_comb begin
      state_nxt = state;
      case (state)
         UART_IDLE:  if (in_valid) state_nxt = UART_START;
         UART_START: if (bit_done) state_nxt = UART_DATA;
         UART_DATA:  if (bit_done && (bit_idx == 3'd7)) state_nxt = UART_STOP;
         UART_STOP:  if (bit_done) state_nxt = in_valid ? UART_START : UART_IDLE;
         default:    state_nxt = UART_IDLE;
      endcase
   end

   // Outputs: line level, busy flag and byte acceptance
   always_comb begin
      tx       = 1'b1;
      busy     = (state != UART_IDLE);
      in_ready = (state == UART_IDLE) || ((state == UART_STOP) && bit_done);
      case (state)
         UART_START: tx = 1'b0;
         UART_DATA:  tx = shift[0];
         default:    tx = 1'b1;
      endcase
   end

   // Baud counter, shift register and bit index; reload at every bit boundary
   always_ff @(posedge clk) begin
      if (!rstb) begin
         baud_cnt <= '0;
         shift    <= '0;
         bit_idx  <= '0;
      end else if (fire) begin
         shift    <= in_data;
         baud_cnt <= RELOAD;
         bit_idx  <= '0;
      end else if (state != UART_IDLE) begin
         if (bit_done) begin
            baud_cnt <= RELOAD;
            if (state == UART_DATA) begin
               shift   <= {1'b0, shift[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            baud_cnt <= baud_cnt - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_mem_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_mmio
//  Purpose  : Memory system for the multicycle MIPS core: word RAM with
//             asynchronous read plus an MMIO page (UART TX FIFO, LEDs,
//             free-running cycle counter). Read data is combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mem_mmio
   import mips_mmio_pkg::*;
#(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 434
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr_ena,
   output logic [31:0] mem_rd_data,
   output logic        uart_tx,
   output logic [7:0]  leds
);

   localparam int RAM_AW  = $clog2(RAM_WORDS);
   localparam int FIFO_AW = $clog2(FIFO_DEPTH);

   // ---------------- address decode ----------------
   logic              is_mmio;
   logic [RAM_AW-1:0] ram_idx;
   logic              sel_tx, sel_status, sel_leds, sel_cycle;
   logic              unused_addr_lsbs;

   assign is_mmio    = (mem_addr[31:16] == MMIO_BASE);
   assign ram_idx    = mem_addr[RAM_AW+1:2];
   assign sel_tx     = is_mmio && (mem_addr[15:2] == OFF_TXDATA[15:2]);
   assign sel_status = is_mmio && (mem_addr[15:2] == OFF_STATUS[15:2]);
   assign sel_leds   = is_mmio && (mem_addr[15:2] == OFF_LEDS[15:2]);
   assign sel_cycle  = is_mmio && (mem_addr[15:2] == OFF_CYCLE[15:2]);
   // Byte lane bits carry no meaning: all accesses are whole words
   assign unused_addr_lsbs = ^mem_addr[1:0];

   // ---------------- RAM ----------------
   logic [31:0] ram [RAM_WORDS];

   // RAM write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (mem_wr_ena && !is_mmio) ram[ram_idx] <= mem_wr_data;
   end

   // ---------------- UART TX FIFO ----------------
   logic [7:0]         fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               fifo_full, fifo_empty;
   logic               push_req, push_ok, pop;
   logic               tx_ready, tx_busy;
   logic               overflow;
   logic [3:0]         cnt_disp;

   assign fifo_full  = (count == (FIFO_AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign push_req   = mem_wr_ena && sel_tx;
   assign pop        = !fifo_empty && tx_ready;
   // A pop in the same cycle frees a slot, so a push while full still fits
   assign push_ok    = push_req && (!fifo_full || pop);
   assign cnt_disp   = (32'(count) > 32'd15) ? 4'hF : 4'(count);

   // FIFO storage; data is don't-care until pushed
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= mem_wr_data[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rstb) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= count + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
         if (mem_wr_ena && sel_status)     overflow <= 1'b0;
         else if (push_req && !push_ok)    overflow <= 1'b1;
      end
   end

   uart_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_uart_tx (
      .clk      (clk),
      .rstb     (rstb),
      .in_data  (fifo_mem[rd_ptr]),
      .in_valid (!fifo_empty),
      .in_ready (tx_ready),
      .tx       (uart_tx),
      .busy     (tx_busy)
   );

   // ---------------- LEDs and cycle counter ----------------
   logic [31:0] cycle_cnt;

   // LED register write
   always_ff @(posedge clk) begin
      if (!rstb)                       leds <= '0;
      else if (mem_wr_ena && sel_leds) leds <= mem_wr_data[7:0];
   end

   // Free-running cycle counter; a write restarts it at zero
   always_ff @(posedge clk) begin
      if (!rstb)                        cycle_cnt <= '0;
      else if (mem_wr_ena && sel_cycle) cycle_cnt <= '0;
      else                              cycle_cnt <= cycle_cnt + 32'd1;
   end

   // ---------------- read mux ----------------
   logic [31:0] status;

   // Combinational read data for the current address
   always_comb begin
      status                     = '0;
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_BUSY]            = tx_busy;
      status[ST_OVF]             = overflow;
      status[ST_CNT_LSB +: 4]    = cnt_disp;
      mem_rd_data                = '0;
      if (!is_mmio)        mem_rd_data = ram[ram_idx];
      else if (sel_status) mem_rd_data = status;
      else if (sel_leds)   mem_rd_data = {24'd0, leds};
      else if (sel_cycle)  mem_rd_data = cycle_cnt;
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_mem_mmio
//  Purpose  : Self-checking bench for mips_mem_mmio (RAM, MMIO, UART framing,
//             FIFO overflow, reset mid-frame).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_mmio;

   logic        clk;
   logic        rstb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_ena;
   logic [31:0] mem_rd_data;
   logic        uart_tx;
   logic [7:0]  leds;

   int checks = 0;
   int errors = 0;

   mips_mem_mmio #(
      .RAM_WORDS  (1024),
      .FIFO_DEPTH (8),
      .CLK_DIV    (4)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ena  (mem_wr_ena),
      .mem_rd_data (mem_rd_data),
      .uart_tx     (uart_tx),
      .leds        (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      mem_addr    = addr;
      mem_wr_data = data;
      mem_wr_ena  = 1'b1;
      step();
      mem_wr_ena  = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      mem_addr = addr;
      #1;
      check(name, mem_rd_data, exp);
   endtask

   // Expected line level k cycles into an 8N1 frame at 4 cycles per bit
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int bt;
      bt = k / 4;
      if (bt == 0) return 1'b0;
      if (bt <= 8) return b[bt-1];
      return 1'b1;
   endfunction

   initial begin
      mem_addr    = 32'h0;
      mem_wr_data = 32'h0;
      mem_wr_ena  = 1'b0;
      rstb        = 1'b0;

      vecs[0]  = '{1'b0, 32'hFFFF0004, 32'h0,        1'b1, 32'h0000_0002};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h0000_1010, 32'h0,        1'b1, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,        1'b1, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 32'h0000_7FFC, 32'hCAFE_F00D, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,        1'b1, 32'hCAFE_F00D};
      vecs[8]  = '{1'b1, 32'hFFFF_0008, 32'h0000_01FF, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 32'hFFFF_0008, 32'h0,        1'b1, 32'h0000_00FF};
      vecs[10] = '{1'b0, 32'hFFFF_0020, 32'h0,        1'b1, 32'h0};
      vecs[11] = '{1'b1, 32'hFFFF_0020, 32'hFFFF_FFFF, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 32'hFFFF_000A, 32'h0,        1'b1, 32'h0000_00FF};
      vecs[13] = '{1'b0, 32'hFFFF_0000, 32'h0,        1'b1, 32'h0};

      // ---- reset state ----
      step();
      step();
      check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_leds", {24'd0, leds}, 32'd0);
      rd_check("rst_status", 32'hFFFF0004, 32'h0000_0002);
      rd_check("rst_cycle", 32'hFFFF000C, 32'd0);
      rstb = 1'b1;
      step();
      rd_check("cycle_after_rst", 32'hFFFF000C, 32'd1);

      // ---- table-driven RAM / register vectors ----
      for (int i = 0; i < 14; i++) begin
         mem_addr    = vecs[i].addr;
         mem_wr_data = vecs[i].wdata;
         mem_wr_ena  = vecs[i].wr;
         #1;
         if (vecs[i].chk) check($sformatf("vec%0d", i), mem_rd_data, vecs[i].exp);
         step();
         mem_wr_ena = 1'b0;
      end
      check("leds_port", {24'd0, leds}, 32'h0000_00FF);

      // ---- cycle counter restart ----
      wr(32'hFFFF000C, 32'h1234_5678);
      rd_check("cycle_cleared", 32'hFFFF000C, 32'd0);
      step(); step(); step();
      rd_check("cycle_plus3", 32'hFFFF000C, 32'd3);

      // ---- single frame 0x55 ----
      wr(32'hFFFF0000, 32'h0000_0055);
      check("tx_before_pop", {31'd0, uart_tx}, 32'd1);
      step();
      mem_addr = 32'hFFFF0004;
      for (int k = 0; k < 40; k++) begin
         #1;
         check($sformatf("f55_tx_k%0d", k), {31'd0, uart_tx}, {31'd0, frame_bit(8'h55, k)});
         check($sformatf("f55_busy_k%0d", k), {31'd0, mem_rd_data[2]}, 32'd1);
         step();
      end
      check("f55_idle_tx", {31'd0, uart_tx}, 32'd1);
      rd_check("f55_status_after", 32'hFFFF0004, 32'h0000_0002);

      // ---- back-to-back frames 0xA5, 0x3C ----
      wr(32'hFFFF0000, 32'h0000_00A5);
      wr(32'hFFFF0000, 32'h0000_003C);
      for (int k = 0; k < 80; k++) begin
         check($sformatf("b2b_tx_k%0d", k), {31'd0, uart_tx},
               {31'd0, frame_bit((k < 40) ? 8'hA5 : 8'h3C, k % 40)});
         step();
      end
      check("b2b_idle_tx", {31'd0, uart_tx}, 32'd1);
      rd_check("b2b_status_after", 32'hFFFF0004, 32'h0000_0002);

      // ---- overflow: 10 back-to-back pushes ----
      for (int i = 0; i < 10; i++) wr(32'hFFFF0000, 32'h0000_0030 + i);
      rd_check("ovf_status", 32'hFFFF0004, 32'h0000_080D);
      wr(32'hFFFF0004, 32'h0);
      rd_check("ovf_cleared", 32'hFFFF0004, 32'h0000_0805);

      // ---- reset in the middle of the DATA bits ----
      for (int i = 0; i < 10; i++) step();
      check("pre_rst_busy", {31'd0, mem_rd_data[2]}, 32'd1);
      rstb = 1'b0;
      step();
      rstb = 1'b1;
      check("midrst_tx", {31'd0, uart_tx}, 32'd1);
      rd_check("midrst_status", 32'hFFFF0004, 32'h0000_0002);
      check("midrst_leds", {24'd0, leds}, 32'd0);
      rd_check("midrst_cycle", 32'hFFFF000C, 32'd0);
      rd_check("midrst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
      for (int i = 0; i < 6; i++) step();
      check("midrst_tx_stays_high", {31'd0, uart_tx}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
